// File: rtl/mlp_layer_sequencer.sv
// Control sequencer for the MLP layer memory and MAC array: loads operands once,
// then runs read / MAC / wait / write-back for each of the M-1 compute layers.
`timescale 1ns/1ps

module mlp_layer_sequencer #(
    parameter int M       = 3,
    parameter int N       = 2,
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     mac_done,
    output logic                     initial_flag,
    output logic                     read_en,
    output logic                     mac_start,
    output logic                     write_en,
    output logic [$clog2(M-1)-1:0]   layer_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [CW-1:0]            cyc_count
);

    localparam int LW = $clog2(M-1);
    localparam int WW = $clog2(TIMEOUT);

    if (M < 3 || N < 1 || TIMEOUT < 2 || CW < 1) begin : g_bad_params
        $error("mlp_layer_sequencer: invalid parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [WW-1:0]   wd_count;
    logic            last_layer;
    logic            wd_expired;
    logic            launch;

    assign last_layer = (layer_addr == LW'(M-2));
    assign wd_expired = (wd_count == WW'(TIMEOUT-1));
    assign launch     = (next_state == S_LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        initial_flag = 1'b0;
        read_en      = 1'b0;
        mac_start    = 1'b0;
        write_en     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_LOAD;
            end
            S_LOAD: begin
                initial_flag = 1'b1;
                busy         = 1'b1;
                next_state   = S_READ;
            end
            S_READ: begin
                read_en    = 1'b1;
                mac_start  = 1'b1;
                busy       = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                read_en = 1'b1;
                busy    = 1'b1;
                // mac_done on the expiry cycle still completes the layer
                if (mac_done)        next_state = S_WRITE;
                else if (wd_expired) next_state = S_ERR;
            end
            S_WRITE: begin
                write_en   = 1'b1;
                busy       = 1'b1;
                next_state = last_layer ? S_DONE : S_READ;
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = start ? S_LOAD : S_IDLE;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) next_state = S_LOAD;
            end
            default: next_state = S_IDLE;
        endcase
        if (abort) next_state = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_addr <= '0;
            wd_count   <= '0;
            cyc_count  <= '0;
        end else begin
            if (abort || launch) begin
                layer_addr <= '0;
            end else if (state == S_WRITE && !last_layer) begin
                layer_addr <= layer_addr + 1'b1;
            end

            if (state == S_READ) begin
                wd_count <= '0;
            end else if (state == S_WAIT) begin
                wd_count <= wd_count + 1'b1;
            end

            // abort freezes the count so the partial run length stays visible
            if (!abort) begin
                if (launch) begin
                    cyc_count <= '0;
                end else if (busy && cyc_count != '1) begin
                    cyc_count <= cyc_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mlp_layer_sequencer.md
Name: mlp_layer_sequencer

Overview:
- Control FSM that drives the MLP layer memory and the N-neuron MAC array through a full inference.
- Sequence: loads x/w/b into memory once, then for each of the M-1 layers issues read, MAC start, waits for MAC completion and commits results back to memory.
- Sits between the testbench/top-level start interface and the memory + MAC datapath.
- Adds a MAC-wait watchdog, abort and a busy-cycle counter for performance checks.

Parameters:
- M, 3, number of network layers including input; the block sequences M-1 compute layers; M >= 3 required.
- N, 2, neurons per layer; informational only, not used in control logic.
- TIMEOUT, 64, maximum cycles in WAIT before error; must be >= 2.
- CW, 16, width of the busy-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin inference; sampled in IDLE, DONE or ERR only.
- abort  in  1  synchronous return to IDLE from any state; priority over all other inputs.
- mac_done  in  1  MAC array finished current layer; sampled only in WAIT.
- initial_flag  out  1  memory load strobe, high in LOAD.
- read_en  out  1  memory read enable, high in READ and WAIT.
- mac_start  out  1  one-cycle MAC start pulse, high in READ.
- write_en  out  1  memory write strobe, high in WRITE.
- layer_addr  out  $clog2(M-1)  current layer index.
- busy  out  1  high in LOAD, READ, WAIT, WRITE, DONE.
- done  out  1  one-cycle completion pulse, high in DONE.
- err  out  1  high in ERR.
- cyc_count  out  CW  busy-cycle count of the current/last run.

Behaviour:
- Moore FSM. All outputs decode from registered state, layer_addr and counters; no input-to-output combinational path.
- Reset (async, rst=1): state=IDLE, layer_addr=0, wd counter=0, cyc_count=0. All outputs 0.
- IDLE: start=1 -> LOAD; clear cyc_count and layer_addr.
- LOAD (1 cycle): -> READ.
- READ (1 cycle): -> WAIT; clear wd counter.
- WAIT:
  - mac_done=1 -> WRITE.
  - else wd counter++; when wd counter reaches TIMEOUT-1 without mac_done -> ERR.
  - mac_done on the timeout cycle wins (-> WRITE).
- WRITE (1 cycle):
  - if layer_addr==M-2 -> DONE.
  - else layer_addr+1 and -> READ, both on the same edge.
- DONE (1 cycle):
  - start=1 -> LOAD (back-to-back run; clear counters).
  - else -> IDLE.
  - layer_addr holds M-2 until the next start.
- ERR: holds until start (-> LOAD, counters cleared) or abort (-> IDLE).
- abort=1 in any state -> IDLE next edge; layer_addr=0; cyc_count holds.
- start outside IDLE/DONE/ERR: ignored.
- mac_done outside WAIT: ignored.
- cyc_count increments on every cycle busy=1; saturates at 2^CW-1; holds when not busy.
- Exactly M-1 write_en pulses per successful run.
  - The memory bank flag toggles per write, so the final results sit in bank 1 when M-1 is odd and in bank 0 when M-1 is even.
  - The integrator reads final results accordingly.
- Reset asserted mid-run: immediate IDLE, all strobes drop asynchronously.

Test Plan:
- M=3. start pulse at edge 0; mac_done high in the 3rd WAIT cycle of each layer.
  - Expected: LOAD c1, READ c2 (mac_start, layer_addr=0), WAIT c3-5, WRITE c6, READ c7 (layer_addr=1), WAIT c8-10, WRITE c11, DONE c12, IDLE c13.
  - cyc_count=12; 2 write_en pulses.
- M=3. mac_done held low after first READ, TIMEOUT=64.
  - Expected: err=1 after 64 WAIT cycles, no write_en.
  - Then a start pulse -> LOAD with err=0 and cyc_count cleared.
- abort asserted in the 2nd WAIT cycle of layer 1.
  - Expected: IDLE next cycle, layer_addr=0, read_en=0, no further write_en.
  - A later mac_done is ignored.
- start held high through DONE.
  - Expected: DONE c12 followed directly by LOAD c13; cyc_count restarts from 0.
- rst asserted during WRITE.
  - Expected: write_en, busy, read_en drop to 0 immediately (asynchronous).
  - After rst release, outputs stay idle until start.
- mac_done pulsed during LOAD and WRITE, start pulsed during WAIT.
  - Expected: all ignored; the sequence matches the first scenario exactly.
